ls_unit: RTL and testbench

Load/store execution unit sitting between the load/store buffer and the memory controller. It accepts one memory operation at a time from the buffer's head, holds `busy` while the operation is in flight, and drives a single-outstanding request to the memory controller. When the data returns, it sign- or zero-extends load data and broadcasts it on the LS CDB. Committed stores always complete; loads are squashed on a branch mispredict.

---
 rtl/ls_unit.sv | 190 +++++++++++++++++++
 tb/tb_ls_unit.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ls_unit.sv
// ----------------------------------------------------------------------------
// ls_unit
// Load/store execution unit between the load/store buffer head and the memory
// controller. One operation is in flight at a time. Loads return data on the
// LS CDB after sign/zero extension. Stores complete silently. A mispredict
// squashes an in-flight load's broadcast but never aborts the memory access.
//
// Ports
//   clk, rst        : clock, synchronous active-high reset
//   rdy             : global ready, low freezes every register
//   misbranch_flag  : branch mispredict flush
//   enable_in       : one-cycle issue strobe from the LS buffer
//   openum_in       : opcode of the issued operation
//   addr_in         : effective address
//   store_data_in   : store data (ignored for loads)
//   rob_id_in       : ROB id of the issued operation
//   busy_out        : unit cannot take an issue next cycle (combinational)
//   mem_req_*       : single-outstanding request to the memory controller
//   mem_done        : one-cycle completion pulse
//   mem_rdata       : raw read data, right-aligned, valid with mem_done
//   cdb_valid       : LS CDB broadcast valid (one cycle)
//   cdb_rob_id      : ROB id being broadcast
//   cdb_result      : extended load result
// ----------------------------------------------------------------------------
module ls_unit #(
    parameter int                ROB_ID_W    = 4,
    parameter int                OP_W        = 6,
    parameter logic [OP_W-1:0]   OPENUM_LB   = OP_W'(11),
    parameter logic [OP_W-1:0]   OPENUM_LH   = OP_W'(12),
    parameter logic [OP_W-1:0]   OPENUM_LW   = OP_W'(13),
    parameter logic [OP_W-1:0]   OPENUM_LBU  = OP_W'(14),
    parameter logic [OP_W-1:0]   OPENUM_LHU  = OP_W'(15),
    parameter logic [OP_W-1:0]   OPENUM_SB   = OP_W'(16),
    parameter logic [OP_W-1:0]   OPENUM_SH   = OP_W'(17),
    parameter logic [OP_W-1:0]   OPENUM_SW   = OP_W'(18)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rdy,
    input  logic                misbranch_flag,
    input  logic                enable_in,
    input  logic [OP_W-1:0]     openum_in,
    input  logic [31:0]         addr_in,
    input  logic [31:0]         store_data_in,
    input  logic [ROB_ID_W-1:0] rob_id_in,
    output logic                busy_out,
    output logic                mem_req_valid,
    output logic                mem_req_write,
    output logic [31:0]         mem_req_addr,
    output logic [1:0]          mem_req_size,
    output logic [31:0]         mem_req_wdata,
    input  logic                mem_done,
    input  logic [31:0]         mem_rdata,
    output logic                cdb_valid,
    output logic [ROB_ID_W-1:0] cdb_rob_id,
    output logic [31:0]         cdb_result
);

    typedef enum logic {
        S_IDLE     = 1'b0,
        S_WAIT_MEM = 1'b1
    } state_t;

    // Loads occupy the low end of the opcode space, stores the high end.
    function automatic logic f_is_load(input logic [OP_W-1:0] op);
        return (op <= OPENUM_LHU);
    endfunction

    function automatic logic [1:0] f_size(input logic [OP_W-1:0] op);
        logic [1:0] sz;
        sz = 2'd2;
        if (op == OPENUM_LB || op == OPENUM_LBU || op == OPENUM_SB)
            sz = 2'd0;
        else if (op == OPENUM_LH || op == OPENUM_LHU || op == OPENUM_SH)
            sz = 2'd1;
        return sz;
    endfunction

    function automatic logic [31:0] f_mask_wdata(input logic [OP_W-1:0] op,
                                                 input logic [31:0]     data);
        logic [31:0] w;
        w = 32'd0;
        if (op == OPENUM_SB)
            w = {24'd0, data[7:0]};
        else if (op == OPENUM_SH)
            w = {16'd0, data[15:0]};
        else if (op == OPENUM_SW)
            w = data;
        return w;
    endfunction

    function automatic logic [31:0] f_extend(input logic [OP_W-1:0] op,
                                             input logic [31:0]     raw);
        logic [31:0] r;
        r = raw;
        if (op == OPENUM_LB)
            r = {{24{raw[7]}}, raw[7:0]};
        else if (op == OPENUM_LH)
            r = {{16{raw[15]}}, raw[15:0]};
        else if (op == OPENUM_LBU)
            r = {24'd0, raw[7:0]};
        else if (op == OPENUM_LHU)
            r = {16'd0, raw[15:0]};
        return r;
    endfunction

    state_t                r_state;
    state_t                w_state_next;
    logic [OP_W-1:0]       r_op;
    logic                  r_write;
    logic [31:0]           r_addr;
    logic [1:0]            r_size;
    logic [31:0]           r_wdata;
    logic [ROB_ID_W-1:0]   r_rob_id;
    logic                  r_squashed;
    logic                  r_cdb_valid;
    logic [ROB_ID_W-1:0]   r_cdb_rob_id;
    logic [31:0]           r_cdb_result;

    logic                  w_accept;
    logic                  w_finish;
    logic                  w_broadcast;

    // A load issued in the mispredict cycle is already wrong-path: drop it.
    // Stores were committed before issue, so they are always taken.
    assign w_accept    = enable_in && !(f_is_load(openum_in) && misbranch_flag);
    assign w_finish    = (r_state == S_WAIT_MEM) && mem_done;
    // A flush coinciding with mem_done still suppresses the load broadcast.
    assign w_broadcast = w_finish && f_is_load(r_op) && !r_squashed && !misbranch_flag;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:     if (w_accept) w_state_next = S_WAIT_MEM;
            S_WAIT_MEM: if (mem_done) w_state_next = S_IDLE;
            default:    w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_op         <= '0;
            r_write      <= 1'b0;
            r_addr       <= 32'd0;
            r_size       <= 2'd0;
            r_wdata      <= 32'd0;
            r_rob_id     <= '0;
            r_squashed   <= 1'b0;
            r_cdb_valid  <= 1'b0;
            r_cdb_rob_id <= '0;
            r_cdb_result <= 32'd0;
        end else if (rdy) begin
            r_state     <= w_state_next;
            r_cdb_valid <= w_broadcast;

            if (r_state == S_IDLE && w_accept) begin
                r_op       <= openum_in;
                r_write    <= !f_is_load(openum_in);
                r_addr     <= addr_in;
                r_size     <= f_size(openum_in);
                r_wdata    <= f_mask_wdata(openum_in, store_data_in);
                r_rob_id   <= rob_id_in;
                r_squashed <= 1'b0;
            end

            if (r_state == S_WAIT_MEM && misbranch_flag && f_is_load(r_op))
                r_squashed <= 1'b1;

            // Result registers hold the last broadcast between completions.
            if (w_broadcast) begin
                r_cdb_rob_id <= r_rob_id;
                r_cdb_result <= f_extend(r_op, mem_rdata);
            end
        end
    end

    // The buffer's issue strobe is registered, so the strobe cycle itself
    // must already report busy.
    assign busy_out      = enable_in || (r_state == S_WAIT_MEM) || rst;
    assign mem_req_valid = (r_state == S_WAIT_MEM);
    assign mem_req_write = (r_state == S_WAIT_MEM) && r_write;
    assign mem_req_addr  = r_addr;
    assign mem_req_size  = r_size;
    assign mem_req_wdata = r_wdata;
    assign cdb_valid     = r_cdb_valid;
    assign cdb_rob_id    = r_cdb_rob_id;
    assign cdb_result    = r_cdb_result;

endmodule

// File: tb/tb_ls_unit.sv
module tb_ls_unit;

    localparam logic [5:0] LB  = 6'd11;
    localparam logic [5:0] LH  = 6'd12;
    localparam logic [5:0] LW  = 6'd13;
    localparam logic [5:0] LBU = 6'd14;
    localparam logic [5:0] LHU = 6'd15;
    localparam logic [5:0] SB  = 6'd16;
    localparam logic [5:0] SH  = 6'd17;
    localparam logic [5:0] SW  = 6'd18;

    logic        clk = 1'b0;
    logic        rst, rdy, misbranch_flag, enable_in;
    logic [5:0]  openum_in;
    logic [31:0] addr_in, store_data_in;
    logic [3:0]  rob_id_in;
    logic        busy_out, mem_req_valid, mem_req_write;
    logic [31:0] mem_req_addr;
    logic [1:0]  mem_req_size;
    logic [31:0] mem_req_wdata;
    logic        mem_done;
    logic [31:0] mem_rdata;
    logic        cdb_valid;
    logic [3:0]  cdb_rob_id;
    logic [31:0] cdb_result;

    int checks = 0;
    int errors = 0;

    ls_unit dut (
        .clk(clk), .rst(rst), .rdy(rdy), .misbranch_flag(misbranch_flag),
        .enable_in(enable_in), .openum_in(openum_in), .addr_in(addr_in),
        .store_data_in(store_data_in), .rob_id_in(rob_id_in),
        .busy_out(busy_out), .mem_req_valid(mem_req_valid),
        .mem_req_write(mem_req_write), .mem_req_addr(mem_req_addr),
        .mem_req_size(mem_req_size), .mem_req_wdata(mem_req_wdata),
        .mem_done(mem_done), .mem_rdata(mem_rdata), .cdb_valid(cdb_valid),
        .cdb_rob_id(cdb_rob_id), .cdb_result(cdb_result)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]  op;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  rob;
        int          lat;       // WAIT_MEM cycles before mem_done is sampled
        logic [31:0] rdata;
        int          flush;     // WAIT_MEM cycle carrying misbranch, -1 = none
        logic        exp_write;
        logic [1:0]  exp_size;
        logic [31:0] exp_wdata;
        logic        exp_cdb;
        logic [31:0] exp_result;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: plain arithmetic on the access rules.
    function automatic logic is_load_m(input logic [5:0] op);
        return (op == LB || op == LH || op == LW || op == LBU || op == LHU);
    endfunction

    function automatic logic [1:0] size_m(input logic [5:0] op);
        if (op == LB || op == LBU || op == SB) return 2'd0;
        if (op == LH || op == LHU || op == SH) return 2'd1;
        return 2'd2;
    endfunction

    function automatic logic [31:0] wdata_m(input logic [5:0] op, input logic [31:0] d);
        if (op == SB) return d % 256;
        if (op == SH) return d % 65536;
        return d;
    endfunction

    function automatic logic [31:0] result_m(input logic [5:0] op, input logic [31:0] raw);
        logic [31:0] b, h;
        b = raw % 256;
        h = raw % 65536;
        case (op)
            LB:      return (b >= 128) ? b - 32'd256 : b;
            LH:      return (h >= 32768) ? h - 32'd65536 : h;
            LBU:     return b;
            LHU:     return h;
            default: return raw;
        endcase
    endfunction

    task automatic do_op(input vec_t v, input string tag);
        enable_in     = 1'b1;
        openum_in     = v.op;
        addr_in       = v.addr;
        store_data_in = v.wdata;
        rob_id_in     = v.rob;
        #1;
        chk({tag, ".busy_issue"}, {31'd0, busy_out}, 32'd1);
        @(posedge clk);
        #1;
        enable_in = 1'b0;
        for (int k = 1; k <= v.lat; k++) begin
            chk({tag, ".req_valid"}, {31'd0, mem_req_valid}, 32'd1);
            chk({tag, ".req_write"}, {31'd0, mem_req_write}, {31'd0, v.exp_write});
            chk({tag, ".req_addr"}, mem_req_addr, v.addr);
            chk({tag, ".req_size"}, {30'd0, mem_req_size}, {30'd0, v.exp_size});
            if (v.exp_write)
                chk({tag, ".req_wdata"}, mem_req_wdata, v.exp_wdata);
            mem_done       = (k == v.lat);
            mem_rdata      = (k == v.lat) ? v.rdata : $urandom;
            misbranch_flag = (k == v.flush);
            tick();
            mem_done       = 1'b0;
            misbranch_flag = 1'b0;
        end
        chk({tag, ".cdb_valid"}, {31'd0, cdb_valid}, {31'd0, v.exp_cdb});
        if (v.exp_cdb) begin
            chk({tag, ".cdb_rob"}, {28'd0, cdb_rob_id}, {28'd0, v.rob});
            chk({tag, ".cdb_result"}, cdb_result, v.exp_result);
        end
        chk({tag, ".req_valid_done"}, {31'd0, mem_req_valid}, 32'd0);
        chk({tag, ".busy_idle"}, {31'd0, busy_out}, 32'd0);
        tick();
        chk({tag, ".cdb_one_cycle"}, {31'd0, cdb_valid}, 32'd0);
    endtask

    vec_t vecs[10];
    vec_t rv;
    logic [5:0] ops[8];

    initial begin
        rst = 1'b1; rdy = 1'b1; misbranch_flag = 1'b0; enable_in = 1'b0;
        openum_in = '0; addr_in = '0; store_data_in = '0; rob_id_in = '0;
        mem_done = 1'b0; mem_rdata = '0;

        //              op   addr          wdata          rob  lat rdata         flush wr sz wdata          cdb result
        vecs[0] = '{LB,  32'h100, 32'h0,        4'd3,  3, 32'h000000F3, -1, 0, 0, 32'h0,        1, 32'hFFFFFFF3};
        vecs[1] = '{LBU, 32'h100, 32'h0,        4'd4,  3, 32'h000000F3, -1, 0, 0, 32'h0,        1, 32'h000000F3};
        vecs[2] = '{SH,  32'h200, 32'hDEADBEEF, 4'd5,  3, 32'h0,        -1, 1, 1, 32'h0000BEEF, 0, 32'h0};
        vecs[3] = '{LH,  32'h104, 32'h0,        4'd6,  2, 32'h12348001, -1, 0, 1, 32'h0,        1, 32'hFFFF8001};
        vecs[4] = '{LHU, 32'h104, 32'h0,        4'd7,  4, 32'hABCD8001, -1, 0, 1, 32'h0,        1, 32'h00008001};
        vecs[5] = '{LW,  32'h108, 32'h0,        4'd8,  3, 32'h12345678,  1, 0, 2, 32'h0,        0, 32'h0};
        vecs[6] = '{SW,  32'h10C, 32'hCAFEF00D, 4'd9,  3, 32'h0,         1, 1, 2, 32'hCAFEF00D, 0, 32'h0};
        vecs[7] = '{LW,  32'h110, 32'h0,        4'd10, 3, 32'h87654321,  3, 0, 2, 32'h0,        0, 32'h0};
        vecs[8] = '{SB,  32'h111, 32'h12345699, 4'd11, 2, 32'h0,        -1, 1, 0, 32'h00000099, 0, 32'h0};
        vecs[9] = '{LW,  32'h114, 32'h0,        4'd12, 2, 32'h0BADF00D, -1, 0, 2, 32'h0,        1, 32'h0BADF00D};

        // Reset state
        tick(); tick();
        chk("rst.req_valid", {31'd0, mem_req_valid}, 32'd0);
        chk("rst.cdb_valid", {31'd0, cdb_valid}, 32'd0);
        chk("rst.busy", {31'd0, busy_out}, 32'd1);
        chk("rst.cdb_result", cdb_result, 32'd0);
        rst = 1'b0;
        #1;
        chk("rst.busy_after", {31'd0, busy_out}, 32'd0);

        for (int i = 0; i < 10; i++)
            do_op(vecs[i], $sformatf("vec%0d", i));

        // Back-to-back: second issue two cycles after mem_done; flush in the
        // broadcast cycle does not cancel the already-registered cdb_valid.
        enable_in = 1'b1; openum_in = LB; addr_in = 32'h400; rob_id_in = 4'd1;
        tick();
        enable_in = 1'b0;
        tick();
        mem_done = 1'b1; mem_rdata = 32'h00000080;
        tick();
        mem_done = 1'b0;
        misbranch_flag = 1'b1;
        #1;
        chk("b2b.cdb_valid_flush", {31'd0, cdb_valid}, 32'd1);
        chk("b2b.result1", cdb_result, 32'hFFFFFF80);
        tick();
        misbranch_flag = 1'b0;
        enable_in = 1'b1; openum_in = LW; addr_in = 32'h404; rob_id_in = 4'd2;
        #1;
        chk("b2b.busy_issue", {31'd0, busy_out}, 32'd1);
        tick();
        enable_in = 1'b0;
        chk("b2b.req_valid2", {31'd0, mem_req_valid}, 32'd1);
        chk("b2b.keep_result", cdb_result, 32'hFFFFFF80);
        chk("b2b.keep_rob", {28'd0, cdb_rob_id}, 32'd1);
        tick();
        mem_done = 1'b1; mem_rdata = 32'h00000005;
        tick();
        mem_done = 1'b0;
        chk("b2b.cdb2", {31'd0, cdb_valid}, 32'd1);
        chk("b2b.result2", cdb_result, 32'd5);
        chk("b2b.rob2", {28'd0, cdb_rob_id}, 32'd2);
        tick();

        // Load issued during a mispredict is dropped; a store is not.
        enable_in = 1'b1; openum_in = LW; misbranch_flag = 1'b1; rob_id_in = 4'd3;
        tick();
        enable_in = 1'b0; misbranch_flag = 1'b0;
        chk("drop.load_req", {31'd0, mem_req_valid}, 32'd0);
        enable_in = 1'b1; openum_in = SW; misbranch_flag = 1'b1; addr_in = 32'h500;
        store_data_in = 32'h11223344;
        tick();
        enable_in = 1'b0; misbranch_flag = 1'b0;
        chk("drop.store_req", {31'd0, mem_req_valid}, 32'd1);
        chk("drop.store_wdata", mem_req_wdata, 32'h11223344);
        mem_done = 1'b1;
        tick();
        mem_done = 1'b0;
        chk("drop.store_cdb", {31'd0, cdb_valid}, 32'd0);
        chk("drop.store_idle", {31'd0, mem_req_valid}, 32'd0);
        tick();

        // rdy low for 4 cycles with enable held
        rdy = 1'b0; enable_in = 1'b1; openum_in = LW; addr_in = 32'h300; rob_id_in = 4'd13;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("rdy.frozen_req", {31'd0, mem_req_valid}, 32'd0);
        end
        rdy = 1'b1;
        tick();
        enable_in = 1'b0;
        chk("rdy.req_after", {31'd0, mem_req_valid}, 32'd1);
        chk("rdy.req_addr", mem_req_addr, 32'h300);
        mem_done = 1'b1; mem_rdata = 32'h42;
        tick();
        mem_done = 1'b0;
        chk("rdy.cdb", {31'd0, cdb_valid}, 32'd1);
        chk("rdy.result", cdb_result, 32'h42);
        tick();
        chk("rdy.single_req", {31'd0, mem_req_valid}, 32'd0);

        // Reset mid-transaction
        enable_in = 1'b1; openum_in = SH; addr_in = 32'h600; store_data_in = 32'hFFFF;
        rob_id_in = 4'd14;
        tick();
        enable_in = 1'b0;
        chk("mrst.req_before", {31'd0, mem_req_valid}, 32'd1);
        rst = 1'b1;
        tick();
        chk("mrst.req_valid", {31'd0, mem_req_valid}, 32'd0);
        chk("mrst.req_write", {31'd0, mem_req_write}, 32'd0);
        chk("mrst.req_addr", mem_req_addr, 32'd0);
        chk("mrst.req_size", {30'd0, mem_req_size}, 32'd0);
        chk("mrst.req_wdata", mem_req_wdata, 32'd0);
        chk("mrst.cdb_valid", {31'd0, cdb_valid}, 32'd0);
        chk("mrst.cdb_rob", {28'd0, cdb_rob_id}, 32'd0);
        chk("mrst.cdb_result", cdb_result, 32'd0);
        rst = 1'b0;
        #1;
        chk("mrst.busy_after", {31'd0, busy_out}, 32'd0);
        tick();

        // Randomized operations against the reference model
        ops = '{LB, LH, LW, LBU, LHU, SB, SH, SW};
        for (int i = 0; i < 40; i++) begin
            rv.op    = ops[$urandom_range(0, 7)];
            rv.addr  = $urandom;
            rv.wdata = $urandom;
            rv.rob   = 4'($urandom_range(1, 15));
            rv.lat   = $urandom_range(2, 5);
            rv.rdata = $urandom;
            rv.flush = ($urandom_range(0, 3) == 0) ? $urandom_range(1, rv.lat) : -1;
            rv.exp_write  = !is_load_m(rv.op);
            rv.exp_size   = size_m(rv.op);
            rv.exp_wdata  = wdata_m(rv.op, rv.wdata);
            rv.exp_cdb    = is_load_m(rv.op) && (rv.flush < 0);
            rv.exp_result = result_m(rv.op, rv.rdata);
            do_op(rv, $sformatf("rnd%0d", i));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
